// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned FQ_DEPTH = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            fault;
    logic            filled;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch buffer: issues PC fetches to instruction memory, pairs each
// response with its PC and hands (pc, instr, fault) to decode; flush drains in-flight fetches.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_valid,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_ready,
  input  logic            flush,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            imem_rsp_err,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_fault,
  output logic            proto_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fq_entry_t       r_entry [DEPTH];
  logic [PW-1:0]   r_alloc_ptr;
  logic [PW-1:0]   r_fill_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_drop_cnt;
  logic            r_proto_err;

  logic [PW-1:0]   w_count;
  logic [PW:0]     w_occupancy;
  logic            w_credit_ok;
  logic            w_pop;
  logic            w_rsp_drop;
  logic            w_rsp_fill;
  logic            w_rsp_bad;
  fq_entry_t       w_head;

  // Buffered entries plus fetches still owed by memory after a flush share the credit pool
  assign w_count     = r_alloc_ptr - r_rd_ptr;
  assign w_occupancy = {1'b0, w_count} + {1'b0, r_drop_cnt};
  assign w_credit_ok = w_occupancy < (PW+1)'(DEPTH);

  assign imem_req_valid = rst & pc_valid & w_credit_ok & ~flush;
  assign imem_req_addr  = pc_i;
  assign pc_ready       = imem_req_valid & imem_req_ready;

  assign w_head   = r_entry[r_rd_ptr[AW-1:0]];
  assign if_valid = (w_count != '0) & w_head.filled & ~flush;
  assign if_pc    = if_valid ? w_head.pc    : '0;
  assign if_instr = if_valid ? w_head.instr : '0;
  assign if_fault = if_valid & w_head.fault;
  assign w_pop    = if_valid & if_ready;

  assign w_rsp_drop = imem_rsp_valid & (r_drop_cnt != '0);
  assign w_rsp_fill = imem_rsp_valid & (r_drop_cnt == '0) & (r_fill_ptr != r_alloc_ptr);
  assign w_rsp_bad  = imem_rsp_valid & (r_drop_cnt == '0) & (r_fill_ptr == r_alloc_ptr);

  assign proto_err = r_proto_err;

  // Pointer, drop counter and sticky protocol error state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_rd_ptr    <= '0;
      r_drop_cnt  <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_rsp_bad) r_proto_err <= 1'b1;
      if (flush) begin
        r_fill_ptr <= r_alloc_ptr;
        r_rd_ptr   <= r_alloc_ptr;
        r_drop_cnt <= r_drop_cnt + (r_alloc_ptr - r_fill_ptr) - PW'(w_rsp_drop | w_rsp_fill);
      end else begin
        if (pc_ready)   r_alloc_ptr <= r_alloc_ptr + PW'(1);
        if (w_rsp_drop) r_drop_cnt  <= r_drop_cnt - PW'(1);
        if (w_rsp_fill) r_fill_ptr  <= r_fill_ptr + PW'(1);
        if (w_pop)      r_rd_ptr    <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Entry storage; alloc, fill and pop always target distinct slots
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_entry[AW'(i)] <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) r_entry[AW'(i)].filled <= 1'b0;
    end else begin
      if (pc_ready) begin
        r_entry[r_alloc_ptr[AW-1:0]].pc     <= pc_i;
        r_entry[r_alloc_ptr[AW-1:0]].filled <= 1'b0;
      end
      if (w_rsp_fill) begin
        r_entry[r_fill_ptr[AW-1:0]].instr  <= imem_rsp_data;
        r_entry[r_fill_ptr[AW-1:0]].fault  <= imem_rsp_err;
        r_entry[r_fill_ptr[AW-1:0]].filled <= 1'b1;
      end
      if (w_pop) r_entry[r_rd_ptr[AW-1:0]].filled <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-level reference model plus an in-order
// memory model with random latency drive the DUT; a separate monitor checks every cycle.
module tb_fetch_queue;
  import fetch_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pc_valid = 1'b0;
  logic [XLEN-1:0] pc_i = '0;
  logic            pc_ready;
  logic            flush = 1'b0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b0;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [XLEN-1:0] imem_rsp_data = '0;
  logic            imem_rsp_err = 1'b0;
  logic            if_valid;
  logic            if_ready = 1'b0;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  logic            if_fault;
  logic            proto_err;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pc_valid(pc_valid), .pc_i(pc_i), .pc_ready(pc_ready), .flush(flush),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .imem_rsp_err(imem_rsp_err),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc),
    .if_instr(if_instr), .if_fault(if_fault), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    int          id;
    int          arr;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          id;
    bit          dead;
    int          due;
  } req_t;

  exp_t sb[$];
  req_t pend[$];
  exp_t mon_e;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  int next_id = 0;
  bit chk_en = 1'b0;
  bit proto_flag = 1'b0;
  bit exp_if_valid = 1'b0;
  bit exp_req_valid = 1'b0;
  bit exp_pc_ready = 1'b0;
  bit exp_proto = 1'b0;
  logic [31:0] cur_pc = '0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h00500093;
      32'h4:   return 32'h00100113;
      32'h8:   return 32'h002081B3;
      default: return (a * 32'h9E3779B1) ^ 32'h5A5A0013;
    endcase
  endfunction

  function automatic logic fault_of(input logic [31:0] a);
    return (a == 32'h40) || (a[31:28] == 4'hF);
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // One clock of stimulus: compute expectations from the model, play memory, drive inputs
  task automatic cyc(input logic pv, input logic [31:0] pc, input logic fl,
                     input logic rdy, input logic rr, input int lat, input logic spur);
    int   occ;
    req_t p;
    logic rv;
    logic [31:0] rd;
    logic re;
    @(negedge clk);
    cyc_n++;
    occ = sb.size();
    foreach (pend[i]) if (pend[i].dead) occ++;
    exp_if_valid  = !fl && sb.size() > 0 && sb[0].arr >= 0 && sb[0].arr < cyc_n;
    exp_req_valid = pv && !fl && occ < DEPTH;
    exp_pc_ready  = exp_req_valid && rr;
    exp_proto     = proto_flag;
    rv = 1'b0; rd = '0; re = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc_n) begin
      p  = pend.pop_front();
      rv = 1'b1; rd = instr_of(p.addr); re = fault_of(p.addr);
      if (!fl && !p.dead) foreach (sb[i]) if (sb[i].id == p.id) sb[i].arr = cyc_n;
    end else if (spur && !fl && pend.size() == 0) begin
      rv = 1'b1; rd = 32'hDEADBEEF; re = 1'b0;
      proto_flag = 1'b1;
    end
    if (fl) begin
      sb.delete();
      foreach (pend[i]) pend[i].dead = 1'b1;
    end
    if (exp_pc_ready) begin
      sb.push_back('{pc: pc, instr: instr_of(pc), fault: fault_of(pc), id: next_id, arr: -1});
      pend.push_back('{addr: pc, id: next_id, dead: 1'b0, due: cyc_n + lat});
      next_id++;
    end
    pc_valid = pv; pc_i = pc; cur_pc = pc; flush = fl;
    if_ready = rdy; imem_req_ready = rr;
    imem_rsp_valid = rv; imem_rsp_data = rd; imem_rsp_err = re;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) cyc(1'b0, 32'h0, 1'b0, rdy, 1'b1, 1, 1'b0);
  endtask

  // Monitor: compares DUT outputs against the model between clock edges
  always begin
    @(negedge clk);
    #2;
    if (chk_en) begin
      check("req_valid", 96'(imem_req_valid), 96'(exp_req_valid));
      check("pc_ready", 96'(pc_ready), 96'(exp_pc_ready));
      if (exp_req_valid) check("req_addr", 96'(imem_req_addr), 96'(cur_pc));
      check("if_valid", 96'(if_valid), 96'(exp_if_valid));
      if (exp_if_valid && if_ready) begin
        mon_e = sb.pop_front();
        check("deliver", {if_pc, if_instr, 31'b0, if_fault},
              {mon_e.pc, mon_e.instr, 31'b0, mon_e.fault});
      end else if (!if_valid) begin
        check("idle_out", 96'({if_pc, if_instr, if_fault}), 96'(0));
      end
      check("proto_err", 96'(proto_err), 96'(exp_proto));
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, with a PC offered to show the request path stays quiet
    repeat (2) @(negedge clk);
    pc_valid = 1'b1; imem_req_ready = 1'b1;
    #1;
    check("rst_if_valid", 96'(if_valid), 96'(0));
    check("rst_pc_ready", 96'(pc_ready), 96'(0));
    check("rst_req_valid", 96'(imem_req_valid), 96'(0));
    check("rst_proto", 96'(proto_err), 96'(0));
    pc_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk_en = 1'b1;

    // Streaming with 1-cycle memory
    cyc(1'b1, 32'h0, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h4, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h8, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    idle(5, 1'b1);

    // Fill to DEPTH with decode stalled, then release one slot
    for (int k = 0; k < 4; k++) cyc(1'b1, 32'h10 + 32'(4 * k), 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h20, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    idle(8, 1'b1);

    // Flush with three fetches in flight, then redirect to 0x100
    cyc(1'b1, 32'h200, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    cyc(1'b1, 32'h204, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    cyc(1'b1, 32'h208, 1'b0, 1'b1, 1'b1, 4, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    idle(10, 1'b1);

    // Flush in the same cycle as a response
    cyc(1'b1, 32'h300, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    cyc(1'b1, 32'h304, 1'b0, 1'b1, 1'b1, 2, 1'b0);
    cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h104, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    idle(8, 1'b1);

    // Access fault, then an unexpected response
    cyc(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    idle(4, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 1, 1'b1);
    idle(3, 1'b1);

    // Asynchronous reset with two entries queued
    cyc(1'b1, 32'h500, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    cyc(1'b1, 32'h504, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    idle(2, 1'b0);
    @(negedge clk);
    chk_en = 1'b0;
    pc_valid = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b1;
    imem_rsp_valid = 1'b0; flush = 1'b0;
    #1 rst = 1'b0;
    #1;
    check("mid_rst_if_valid", 96'(if_valid), 96'(0));
    check("mid_rst_pc_ready", 96'(pc_ready), 96'(0));
    sb.delete(); pend.delete(); proto_flag = 1'b0;
    repeat (2) @(negedge clk);
    pc_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("post_rst_proto", 96'(proto_err), 96'(0));
    check("post_rst_empty", 96'(if_valid), 96'(0));
    exp_req_valid = 1'b0; exp_pc_ready = 1'b0; exp_if_valid = 1'b0; exp_proto = 1'b0;
    chk_en = 1'b1;
    idle(2, 1'b1);

    // Randomized traffic
    for (int k = 0; k < 2500; k++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom & 32'hFFFFFFFC,
          1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 3) != 0), int'($urandom_range(1, 4)),
          1'($urandom_range(0, 59) == 0));
    end

    // Drain everything outstanding
    for (int k = 0; k < 300 && (sb.size() != 0 || pend.size() != 0); k++) idle(1, 1'b1);
    check("drained", 96'(sb.size() + pend.size()), 96'(0));
    idle(2, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
